rice_stream_decoder: RTL and testbench

- Single-clock, parametrised Rice (split-sample) decoder for CCSDS-style compressed telemetry packets.
- Next generation of the two-clock preprocessing/decode path: one clock domain, a configurable sample width and block size, and a per-block option header that selects either a split-k code or raw (uncompressed) samples.
- Accepts packed bitstream words with valid/ready and emits decoded samples with valid/ready and a block-last marker.
- Sits between the telemetry frame extractor and the sample reconstruction stage.

---
 rtl/rice_pkg.sv | 24 ++
 rtl/rice_stream_decoder_if.sv | 31 +++
 rtl/rice_bitbuf.sv | 47 ++++
 rtl/rice_stream_decoder.sv | 232 +++++++++++++++++++++++
 tb/tb_rice_stream_decoder.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rice_pkg.sv
// Shared constants, FSM state codes and width helpers for the Rice stream decoder.
package rice_pkg;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_HDR   = 3'd1;
   localparam logic [2:0] S_FS    = 3'd2;
   localparam logic [2:0] S_SPLIT = 3'd3;
   localparam logic [2:0] S_RAW   = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   // Option-header code selecting raw samples; truncated to the header width at use.
   localparam logic [31:0] KID_RAW = '1;

   typedef struct packed {
      logic [5:0]  n;
      logic [6:0]  j;
      logic [15:0] blocks;
   } cfg_t;

   function automatic int unsigned bits_for(input int unsigned v);
      return $clog2(v + 1);
   endfunction

endpackage

// File: rtl/rice_stream_decoder_if.sv
// Control, bitstream-in and sample-out signals of the Rice stream decoder.
interface rice_stream_decoder_if #(
   parameter int unsigned IN_W  = 32,
   parameter int unsigned N_MAX = 32
);
   logic              go;
   logic [5:0]        cfg_n;
   logic [6:0]        cfg_j;
   logic [15:0]       cfg_blocks;
   logic [IN_W-1:0]   in_data;
   logic              in_valid;
   logic              in_ready;
   logic [N_MAX-1:0]  out_sample;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic              busy;
   logic              done;
   logic              err_fs_overflow;
   logic              err_hdr;

   modport master (
      output go, cfg_n, cfg_j, cfg_blocks, in_data, in_valid, out_ready,
      input  in_ready, out_sample, out_valid, out_last, busy, done, err_fs_overflow, err_hdr
   );

   modport slave (
      input  go, cfg_n, cfg_j, cfg_blocks, in_data, in_valid, out_ready,
      output in_ready, out_sample, out_valid, out_last, busy, done, err_fs_overflow, err_hdr
   );
endinterface

// File: rtl/rice_bitbuf.sv
// MSB-aligned bit buffer: word fill, peek of the top N_MAX bits, consume 0..N_MAX bits.
module rice_bitbuf
   import rice_pkg::*;
#(
   parameter int unsigned IN_W   = 32,
   parameter int unsigned N_MAX  = 32,
   parameter int unsigned BUF_W  = 64,
   localparam int unsigned CNT_W  = bits_for(BUF_W),
   localparam int unsigned TAKE_W = bits_for(N_MAX)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              fill,
   input  logic [IN_W-1:0]   fill_data,
   input  logic [TAKE_W-1:0] take,
   output logic [N_MAX-1:0]  peek,
   output logic [CNT_W-1:0]  cnt
);
   logic [BUF_W-1:0] data;
   logic [BUF_W-1:0] kept;
   logic [BUF_W-1:0] placed;
   logic [CNT_W-1:0] rem;

   // Bits below the valid count are always zero, so a new word can simply be OR-ed in.
   always_comb begin
      rem    = cnt - CNT_W'(take);
      kept   = data << take;
      placed = {fill_data, {(BUF_W-IN_W){1'b0}}} >> rem;
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         data <= '0;
         cnt  <= '0;
      end else if (fill) begin
         data <= kept | placed;
         cnt  <= rem + CNT_W'(IN_W);
      end else begin
         data <= kept;
         cnt  <= rem;
      end
   end

   assign peek = data[BUF_W-1 -: N_MAX];

endmodule

// File: rtl/rice_stream_decoder.sv
// Single-clock Rice split-sample decoder: per-block option header, split-k or raw samples,
// valid/ready bitstream in and sample out with a block-last marker.
module rice_stream_decoder
   import rice_pkg::*;
#(
   parameter int unsigned IN_W  = 32,
   parameter int unsigned N_MAX = 32,
   parameter int unsigned J_MAX = 64,
   parameter int unsigned KID_W = 5,
   parameter int unsigned BUF_W = 2 * IN_W
) (
   input logic                  clk,
   input logic                  reset,
   rice_stream_decoder_if.slave bus
);
   localparam int unsigned CNT_W  = bits_for(BUF_W);
   localparam int unsigned TAKE_W = bits_for(N_MAX);
   localparam logic [KID_W-1:0] KID_ALL = KID_W'(KID_RAW);

   logic [2:0]        state, state_d;
   cfg_t              cfg_q, cfg_d;
   logic [KID_W-1:0]  k_q, k_d;
   logic [N_MAX-1:0]  fs_q, fs_d;
   logic [6:0]        smp_q, smp_d;
   logic [15:0]       blk_q, blk_d;
   logic [N_MAX-1:0]  sample_q, sample_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_fs_q, err_fs_d;
   logic              err_hdr_q, err_hdr_d;

   logic [N_MAX-1:0]  peek;
   logic [CNT_W-1:0]  cnt;
   logic [TAKE_W-1:0] take;
   logic              buf_clear;
   logic              in_ready_c;
   logic              fill_c;

   logic              free;
   logic              load;
   logic              abort;
   logic [N_MAX-1:0]  new_sample;
   logic [N_MAX-1:0]  mask;
   logic [N_MAX-1:0]  lsbs;
   logic [N_MAX-1:0]  raw_bits;
   logic [KID_W-1:0]  kf;
   logic [N_MAX:0]    fs_inc;
   logic [N_MAX:0]    fs_limit;

   assign in_ready_c = (state != S_IDLE) && (32'(cnt) <= BUF_W - IN_W);
   assign fill_c     = bus.in_valid && in_ready_c;

   rice_bitbuf #(
      .IN_W  (IN_W),
      .N_MAX (N_MAX),
      .BUF_W (BUF_W)
   ) u_buf (
      .clk       (clk),
      .reset     (reset),
      .clear     (buf_clear),
      .fill      (fill_c),
      .fill_data (bus.in_data),
      .take      (take),
      .peek      (peek),
      .cnt       (cnt)
   );

   // Field extraction from the buffer head and unary-overflow bound.
   always_comb begin
      kf       = peek[N_MAX-1 -: KID_W];
      mask     = ~({N_MAX{1'b1}} << cfg_q.n);
      lsbs     = peek >> (N_MAX - 32'(k_q));
      raw_bits = peek >> (N_MAX - 32'(cfg_q.n));
      fs_inc   = {1'b0, fs_q} + (N_MAX+1)'(1);
      fs_limit = (N_MAX+1)'(1) << (32'(cfg_q.n) - 32'(k_q));
   end

   always_comb begin
      state_d    = state;
      cfg_d      = cfg_q;
      k_d        = k_q;
      fs_d       = fs_q;
      smp_d      = smp_q;
      blk_d      = blk_q;
      sample_d   = sample_q;
      valid_d    = valid_q && !bus.out_ready;
      last_d     = last_q;
      done_d     = 1'b0;
      err_fs_d   = err_fs_q;
      err_hdr_d  = err_hdr_q;
      take       = '0;
      buf_clear  = 1'b0;
      load       = 1'b0;
      abort      = 1'b0;
      new_sample = '0;
      free       = !valid_q || bus.out_ready;

      case (state)
         S_IDLE: begin
            if (bus.go) begin
               cfg_d     = '{n: bus.cfg_n, j: bus.cfg_j, blocks: bus.cfg_blocks};
               err_fs_d  = 1'b0;
               err_hdr_d = 1'b0;
               smp_d     = '0;
               blk_d     = '0;
               state_d   = S_HDR;
            end
         end
         S_HDR: begin
            if (32'(cnt) >= KID_W) begin
               take  = TAKE_W'(KID_W);
               k_d   = kf;
               fs_d  = '0;
               smp_d = '0;
               if (kf == KID_ALL) begin
                  state_d = S_RAW;
               end else if (32'(kf) >= 32'(cfg_q.n)) begin
                  err_hdr_d = 1'b1;
                  state_d   = S_RAW;
               end else begin
                  state_d = S_FS;
               end
            end
         end
         S_FS: begin
            if (cnt != '0) begin
               take = TAKE_W'(1);
               if (peek[N_MAX-1]) begin
                  state_d = S_SPLIT;
               end else if (fs_inc == fs_limit) begin
                  err_fs_d = 1'b1;
                  abort    = 1'b1;
               end else begin
                  fs_d = fs_q + N_MAX'(1);
               end
            end
         end
         S_SPLIT: begin
            if ((32'(cnt) >= 32'(k_q)) && free) begin
               take       = TAKE_W'(k_q);
               load       = 1'b1;
               new_sample = ((fs_q << k_q) | lsbs) & mask;
               fs_d       = '0;
               state_d    = S_FS;
            end
         end
         S_RAW: begin
            if ((32'(cnt) >= 32'(cfg_q.n)) && free) begin
               take       = TAKE_W'(cfg_q.n);
               load       = 1'b1;
               new_sample = raw_bits & mask;
            end
         end
         S_DONE: begin
            // Leftover buffer bits are packet padding.
            if (!valid_q) begin
               done_d    = 1'b1;
               buf_clear = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Sample emission and block/packet boundary; J is clamped to J_MAX.
      if (load) begin
         sample_d = new_sample;
         valid_d  = 1'b1;
         last_d   = 1'b0;
         smp_d    = smp_q + 7'd1;
         if ((32'(smp_q) + 32'd1 == 32'(cfg_q.j)) || (32'(smp_q) + 32'd1 >= J_MAX)) begin
            last_d  = 1'b1;
            smp_d   = '0;
            blk_d   = blk_q + 16'd1;
            state_d = (32'(blk_q) + 32'd1 >= 32'(cfg_q.blocks)) ? S_DONE : S_HDR;
         end
      end

      if (abort) begin
         buf_clear = 1'b1;
         valid_d   = 1'b0;
         done_d    = 1'b1;
         state_d   = S_IDLE;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cfg_q     <= '0;
         k_q       <= '0;
         fs_q      <= '0;
         smp_q     <= '0;
         blk_q     <= '0;
         sample_q  <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_fs_q  <= 1'b0;
         err_hdr_q <= 1'b0;
      end else begin
         state     <= state_d;
         cfg_q     <= cfg_d;
         k_q       <= k_d;
         fs_q      <= fs_d;
         smp_q     <= smp_d;
         blk_q     <= blk_d;
         sample_q  <= sample_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_fs_q  <= err_fs_d;
         err_hdr_q <= err_hdr_d;
      end
   end

   assign bus.in_ready        = in_ready_c;
   assign bus.out_sample      = sample_q;
   assign bus.out_valid       = valid_q;
   assign bus.out_last        = last_q;
   assign bus.busy            = busy_q;
   assign bus.done            = done_q;
   assign bus.err_fs_overflow = err_fs_q;
   assign bus.err_hdr         = err_hdr_q;

endmodule

// File: tb/tb_rice_stream_decoder.sv
// Bench for rice_stream_decoder: directed table, backpressure/reset sequences, random packets vs a bit-level model.
module tb_rice_stream_decoder;

   localparam int unsigned IN_W  = 32;
   localparam int unsigned N_MAX = 32;
   localparam int unsigned KID_W = 4;

   typedef struct packed {
      logic [31:0] s;
      logic        l;
   } exp_t;

   typedef struct packed {
      logic [5:0]       n;
      logic [6:0]       j;
      logic [15:0]      blocks;
      logic [31:0]      word;
      logic [2:0]       ns;
      logic [3:0][31:0] s;
      logic [3:0]       l;
      logic             eh;
      logic             ef;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rice_stream_decoder_if #(.IN_W(IN_W), .N_MAX(N_MAX)) bus ();

   rice_stream_decoder #(
      .IN_W  (IN_W),
      .N_MAX (N_MAX),
      .J_MAX (64),
      .KID_W (KID_W),
      .BUF_W (2 * IN_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   vectors     = 0;
   int   miscompares = 0;
   int   cur_tag     = 0;
   bit   mq[$];
   vec_t tab[5];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s[%0d]: got %0h want %0h", name, cur_tag, got, want);
      end
   endtask

   function automatic vec_t mkv(input int n, input int j, input int b, input logic [31:0] w,
                                input int ns, input logic [31:0] s0, input logic [31:0] s1,
                                input logic [31:0] s2, input logic [31:0] s3,
                                input logic [3:0] l, input bit eh, input bit ef);
      vec_t v;
      v.n = 6'(n); v.j = 7'(j); v.blocks = 16'(b); v.word = w; v.ns = 3'(ns);
      v.s[0] = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3;
      v.l = l; v.eh = eh; v.ef = ef;
      return v;
   endfunction

   // Reference decoder: reads the bit queue by the Rice rules using plain integers.
   function automatic longint rd(input int w);
      longint v = 0;
      for (int i = 0; i < w; i++) v = (v << 1) | longint'(mq.pop_front());
      return v;
   endfunction

   task automatic model(input int n, input int j, input int blocks,
                        output exp_t q[$], output bit eh, output bit ef);
      exp_t e;
      q = {}; eh = 0; ef = 0;
      for (int b = 0; b < blocks; b++) begin
         longint k = rd(KID_W);
         bit raw = (k == 15) || (k >= n);
         if (k != 15 && k >= n) eh = 1;
         for (int s = 0; s < j; s++) begin
            longint v;
            if (raw) v = rd(n);
            else begin
               longint fs = 0;
               while (rd(1) == 0) begin
                  fs++;
                  if (fs == (longint'(1) << (n - k))) begin ef = 1; return; end
               end
               v = ((fs << k) + rd(int'(k))) % (longint'(1) << n);
            end
            e.s = 32'(v); e.l = (s == j - 1);
            q.push_back(e);
         end
      end
   endtask

   task automatic gen_packet(output int n, output int j, output int blocks, output logic [31:0] words[$]);
      bit bits[$];
      logic [31:0] w;
      words = {};
      n = $urandom_range(1, 32); j = $urandom_range(1, 8); blocks = $urandom_range(1, 3);
      for (int b = 0; b < blocks; b++) begin
         int sel = $urandom_range(0, 9);
         int k;
         if (sel == 0) k = 15;
         else if (sel == 1 && n <= 14) k = $urandom_range(n, 14);
         else k = $urandom_range(0, (n - 1 < 14) ? n - 1 : 14);
         for (int i = KID_W - 1; i >= 0; i--) bits.push_back(1'((k >> i) & 1));
         for (int s = 0; s < j; s++) begin
            if (k == 15 || k >= n) begin
               for (int i = 0; i < n; i++) bits.push_back(1'($urandom_range(0, 1)));
            end else begin
               int lim = (n - k >= 4) ? 12 : (1 << (n - k)) - 1;
               int fs  = $urandom_range(0, lim);
               for (int i = 0; i < fs; i++) bits.push_back(1'b0);
               bits.push_back(1'b1);
               for (int i = 0; i < k; i++) bits.push_back(1'($urandom_range(0, 1)));
            end
         end
      end
      while (bits.size() % 32 != 0) bits.push_back(1'b0);
      mq = bits;
      for (int i = 0; i < bits.size(); i += 32) begin
         for (int b = 0; b < 32; b++) w[31-b] = bits[i+b];
         words.push_back(w);
      end
   endtask

   // mode 0: always ready; 1: out_ready 1,0,0,1 with gapped in_valid and a go while busy; 2: random.
   task automatic run_packet(input int n, input int j, input int blocks, input logic [31:0] words[$],
                             input exp_t eq[$], input bit eh, input bit ef, input int mode);
      int widx = 0, got = 0;
      bit seen_done = 0, stall = 0, iv;
      logic [31:0] hold_s;
      logic hold_l;
      @(negedge clk);
      bus.cfg_n = 6'(n); bus.cfg_j = 7'(j); bus.cfg_blocks = 16'(blocks); bus.go = 1'b1;
      @(negedge clk);
      bus.go = 1'b0;
      for (int it = 0; it < 4000 && !seen_done; it++) begin
         case (mode)
            0:       begin bus.out_ready = 1'b1; iv = 1; end
            1:       begin bus.out_ready = (it % 4 == 0) || (it % 4 == 3); iv = (it % 3 != 1); end
            default: begin bus.out_ready = ($urandom_range(0, 9) < 7); iv = ($urandom_range(0, 9) < 7); end
         endcase
         bus.in_valid = iv && (widx < words.size());
         bus.in_data  = (widx < words.size()) ? words[widx] : '0;
         bus.go       = (mode == 1) && (it == 3) && bus.busy;
         #1;
         if (stall) begin
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_sample", 64'(bus.out_sample), 64'(hold_s));
            chk("hold_last", 64'(bus.out_last), 64'(hold_l));
         end
         if (bus.out_valid && bus.out_ready) begin
            if (got < eq.size()) begin
               chk("sample", 64'(bus.out_sample), 64'(eq[got].s));
               chk("last", 64'(bus.out_last), 64'(eq[got].l));
            end else chk("extra_sample", 64'(got + 1), 64'(eq.size()));
            got++;
         end
         stall  = bus.out_valid && !bus.out_ready;
         hold_s = bus.out_sample;
         hold_l = bus.out_last;
         if (bus.in_valid && bus.in_ready) widx++;
         if (bus.done) begin
            seen_done = 1;
            chk("busy_at_done", 64'(bus.busy), 64'd0);
         end else @(negedge clk);
      end
      bus.go = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      chk("done_seen", 64'(seen_done), 64'd1);
      chk("sample_count", 64'(got), 64'(eq.size()));
      chk("err_hdr", 64'(bus.err_hdr), 64'(eh));
      chk("err_fs_overflow", 64'(bus.err_fs_overflow), 64'(ef));
   endtask

   task automatic run_table(input int t, input int mode);
      logic [31:0] wq[$];
      exp_t eq[$];
      exp_t e;
      wq.push_back(tab[t].word);
      for (int i = 0; i < int'(tab[t].ns); i++) begin
         e.s = tab[t].s[i]; e.l = tab[t].l[i];
         eq.push_back(e);
      end
      run_packet(int'(tab[t].n), int'(tab[t].j), int'(tab[t].blocks), wq, eq,
                 tab[t].eh, tab[t].ef, mode);
   endtask

   task automatic check_idle_outputs();
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_sample", 64'(bus.out_sample), 64'd0);
      chk("rst_out_last", 64'(bus.out_last), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_err_fs", 64'(bus.err_fs_overflow), 64'd0);
      chk("rst_err_hdr", 64'(bus.err_hdr), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
   endtask

   initial begin
      int got;
      bit acc;
      tab[0] = mkv(8, 4, 1, 32'h2582F000, 4, 5, 0, 13, 3, 4'b1000, 0, 0);
      tab[1] = mkv(8, 2, 1, 32'hFA53C000, 2, 'hA5, 'h3C, 0, 0, 4'b0010, 0, 0);
      tab[2] = mkv(8, 2, 2, 32'h259F4A78, 4, 5, 0, 'hA5, 'h3C, 4'b1010, 0, 0);
      tab[3] = mkv(4, 2, 1, 32'h6A300000, 2, 'hA, 3, 0, 0, 4'b0010, 1, 0);
      tab[4] = mkv(4, 4, 1, 32'h00000000, 0, 0, 0, 0, 0, 4'b0000, 0, 1);

      reset = 1'b1;
      bus.go = 1'b0; bus.cfg_n = '0; bus.cfg_j = '0; bus.cfg_blocks = '0;
      bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_idle_outputs();
      reset = 1'b0;

      for (int t = 0; t < 5; t++) begin
         cur_tag = t;
         run_table(t, 0);
      end

      cur_tag = 10;
      run_table(0, 1);

      // Reset after the second split sample, then rerun the same packet.
      cur_tag = 20;
      got = 0; acc = 0;
      @(negedge clk);
      bus.cfg_n = tab[0].n; bus.cfg_j = tab[0].j; bus.cfg_blocks = tab[0].blocks; bus.go = 1'b1;
      @(negedge clk);
      bus.go = 1'b0; bus.in_valid = 1'b1; bus.in_data = tab[0].word; bus.out_ready = 1'b1;
      for (int it = 0; it < 100 && got < 2; it++) begin
         if (acc) bus.in_valid = 1'b0;
         #1;
         if (bus.out_valid && bus.out_ready) got++;
         if (bus.in_valid && bus.in_ready) acc = 1;
         if (got < 2) @(negedge clk);
      end
      chk("pre_reset_samples", 64'(got), 64'd2);
      @(negedge clk);
      reset = 1'b1; bus.in_valid = 1'b0;
      @(negedge clk);
      #1;
      check_idle_outputs();
      reset = 1'b0; bus.out_ready = 1'b0;
      cur_tag = 21;
      run_table(0, 0);

      for (int p = 0; p < 40; p++) begin
         int n, j, b;
         logic [31:0] wq[$];
         exp_t eq[$];
         bit eh, ef;
         gen_packet(n, j, b, wq);
         model(n, j, b, eq, eh, ef);
         cur_tag = 100 + p;
         run_packet(n, j, b, wq, eq, eh, ef, 2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
